qbus_master_seq: RTL and testbench
==================================

Name: qbus_master_seq

Overview:
- Q-bus (MPI) master-cycle sequencer between the VM2 core datapath and the external bus.
- Turns single-word read/write requests from the core into DATI/DATO/DATOB bus cycles: address phase with SYNC, data phase with DIN/DOUT, RPLY handshake.
- Owns the bus-grant decision: arbitrates external DMA requests (DMR/DMGO/SACK) against core requests, and takes DMA only between cycles.
- Replaces the core's free-running f1..f4 fetch sequencing with a handshake-driven controller.

Parameters:
- TMO_CYCLES, 64: data-phase clocks without RPLY before a bus timeout (timeout build only); legal range 2..1023.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous active-high reset
- req  in  1  core bus request; held until ack
- we  in  1  1 = write (DATO/DATOB), 0 = read (DATI); sampled with req
- byte  in  1  write only: 1 = byte write (DATOB)
- addr  in  16  cycle address; sampled with req
- wdata  in  16  write data; sampled with req
- ack  out  1  one-clock completion pulse
- err  out  1  one-clock timeout pulse, coincident with ack
- rdata  out  16  read data; valid from the ack cycle until the next read completes
- busy  out  1  high in every state except IDLE
- sync  out  1  bus SYNC, active low
- din  out  1  bus DIN, active low
- dout  out  1  bus DOUT, active low
- wtbt  out  1  bus WTBT, active low
- ad_out  out  16  AD drive value
- ad_oe  out  1  AD output enable; pad tristates when 0
- ad_in  in  16  AD receive value
- rply  in  1  bus RPLY, active low
- dmr  in  1  DMA request, active low
- sack  in  1  DMA acknowledge, active low
- dmgo  out  1  DMA grant, active low

Behaviour:
- Reset (sync, 1 clk): state IDLE; sync=din=dout=wtbt=dmgo=1; ad_oe=0; ad_out=0; ack=err=0; rdata=0; busy=0. Reset mid-cycle releases all bus lines on the same edge.
- All outputs registered. Inputs rply, dmr and sack go through 2-flop synchronisers (2-clk latency), included in every latency figure below.
- IDLE, evaluated in priority order:
  - synced dmr=0 -> GRANT (DMA wins over req).
  - else req=1 and ack=0 -> ADDR; latch we/byte/addr/wdata.
  - A req still high during the ack clock is ignored.
- ADDR, 1 clk:
  - ad_oe=1, ad_out=addr, sync=0.
  - wtbt=0 if we=1, else 1.
  - Next: DATA.
- DATA:
  - Read: ad_oe=0, din=0.
  - Write: ad_out=wdata, dout=0; wtbt=0 if byte=1, else 1.
  - sync stays 0.
  - Stays in DATA until synced rply=0. On that edge: latch rdata=ad_in (reads only), go to DONE.
- DONE:
  - din=dout=1, ad_oe=0, wtbt=1, sync stays 0.
  - Waits for synced rply=1, then: sync=1, state IDLE, ack=1 for one clock.
- GRANT:
  - dmgo=0.
  - Synced sack=0 -> HOLD.
  - Synced dmr=1 before sack -> IDLE, dmgo=1.
- HOLD:
  - dmgo=1; sync, din, dout and wtbt all released; ad_oe=0.
  - Synced sack=1 -> IDLE.
- Latency, read with zero-wait slave (rply falls the clock after din asserts):
  - req edge N -> ADDR N+1 -> DATA N+2 -> DONE N+5 -> IDLE and ack N+7 + slave RPLY release time.
- dmr asserted during a core cycle: the cycle completes; GRANT is entered on the IDLE clock after ack.
- rply low during ADDR: ignored.
- rply stuck low after the data phase: the block stays in DONE indefinitely (no timeout there).

Optional Feature:
- Macro: QBUS_TIMEOUT_EN.
- Defined:
  - A 10-bit counter clears on entry to DATA and increments each DATA clock.
  - Count reaching TMO_CYCLES with no synced rply: din=dout=1, wtbt=1, sync=1, ad_oe=0; state IDLE; ack=err=1 for one clock; rdata=0.
  - DONE itself has no timeout.
- Undefined: no counter; DATA waits indefinitely; err tied 0.

Test Plan:
- Read: addr=0x1000, slave returns 0x0137 with 1-clk rply -> sync low from ADDR through DONE; din low only in DATA; ack pulse with rdata=0x0137; busy low the clock after ack.
- Word write and byte write:
  - addr=0x2002, wdata=0xA5A5, byte=0 -> wtbt=0 in ADDR, 1 in DATA; ad_out=0xA5A5 while dout=0.
  - Repeat with byte=1 -> wtbt=0 in DATA.
- DMA during cycle: assert dmr=0 in DATA of a read -> read completes with ack first; dmgo=0 on the clock after ack; sack=0 -> dmgo=1, ad_oe=0; sack=1 -> IDLE; a pending req then starts ADDR.
- DMA withdrawn: dmr=0 then 1 without sack -> dmgo returns to 1, state IDLE, no bus lines asserted.
- Timeout (QBUS_TIMEOUT_EN, TMO_CYCLES=8), read with no rply -> din released and sync=1 after 8 DATA clocks; ack=err=1 for one clock; rdata=0. Without the macro -> busy stays 1 past 100 clocks.
- Reset in DATA of a write: rst=1 for 1 clk -> next clock sync=dout=wtbt=1, ad_oe=0, busy=0, no ack.

Source files
------------

// File: rtl/qbus_master_seq.sv
// Q-bus (MPI) master-cycle sequencer: DATI/DATO/DATOB cycles plus DMA bus-grant arbitration.
// Define QBUS_TIMEOUT_EN to enable the data-phase RPLY timeout (TMO_CYCLES clocks).
module qbus_master_seq #(
    parameter int TMO_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        byte_en,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        sync,
    output logic        din,
    output logic        dout,
    output logic        wtbt,
    output logic [15:0] ad_out,
    output logic        ad_oe,
    input  logic [15:0] ad_in,
    input  logic        rply,
    input  logic        dmr,
    input  logic        sack,
    output logic        dmgo
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, GRANT, HOLD} state_t;

    generate
        if (TMO_CYCLES < 2 || TMO_CYCLES > 1023) begin : g_bad_tmo
            $error("qbus_master_seq: TMO_CYCLES must be in 2..1023");
        end
    endgenerate

    state_t      state_reg, state_next;
    logic [2:0]  pin_meta_reg, pin_sync_reg;
    logic        rply_s, dmr_s, sack_s;
    logic        we_reg, we_next;
    logic        byte_reg, byte_next;
    logic [15:0] wdata_reg, wdata_next;
    logic        sync_reg, sync_next;
    logic        din_reg, din_next;
    logic        dout_reg, dout_next;
    logic        wtbt_reg, wtbt_next;
    logic        dmgo_reg, dmgo_next;
    logic        ad_oe_reg, ad_oe_next;
    logic [15:0] ad_out_reg, ad_out_next;
    logic        ack_reg, ack_next;
    logic        err_reg, err_next;
    logic [15:0] rdata_reg, rdata_next;
    logic        drive_data;
    logic        tmo_hit;

    // Asynchronous bus handshakes pass through two flops; idle level is 1 (active low).
    always_ff @(posedge clk) begin
        if (rst) begin
            pin_meta_reg <= 3'b111;
            pin_sync_reg <= 3'b111;
        end else begin
            pin_meta_reg <= {sack, dmr, rply};
            pin_sync_reg <= pin_meta_reg;
        end
    end

    assign rply_s = pin_sync_reg[0];
    assign dmr_s  = pin_sync_reg[1];
    assign sack_s = pin_sync_reg[2];

`ifdef QBUS_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(TMO_CYCLES - 1);
    logic [9:0] tmo_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || state_reg != DATA) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 10'd1;
        end
    end

    assign tmo_hit = (state_reg == DATA) && (tmo_cnt_reg == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    // Outputs are computed for the state being entered so they register on the same edge.
    always_comb begin
        state_next  = state_reg;
        we_next     = we_reg;
        byte_next   = byte_reg;
        wdata_next  = wdata_reg;
        sync_next   = 1'b1;
        din_next    = 1'b1;
        dout_next   = 1'b1;
        wtbt_next   = 1'b1;
        dmgo_next   = 1'b1;
        ad_oe_next  = 1'b0;
        ad_out_next = ad_out_reg;
        ack_next    = 1'b0;
        err_next    = 1'b0;
        rdata_next  = rdata_reg;
        drive_data  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!dmr_s) begin
                    state_next = GRANT;
                    dmgo_next  = 1'b0;
                end else if (req && !ack_reg) begin
                    state_next  = ADDR;
                    we_next     = we;
                    byte_next   = byte_en;
                    wdata_next  = wdata;
                    sync_next   = 1'b0;
                    ad_oe_next  = 1'b1;
                    ad_out_next = addr;
                    wtbt_next   = ~we;
                end
            end
            ADDR: begin
                state_next = DATA;
                drive_data = 1'b1;
            end
            DATA: begin
                if (!rply_s) begin
                    state_next = DONE;
                    sync_next  = 1'b0;
                    if (!we_reg) begin
                        rdata_next = ad_in;
                    end
                end else if (tmo_hit) begin
                    state_next = IDLE;
                    ack_next   = 1'b1;
                    err_next   = 1'b1;
                    rdata_next = '0;
                end else begin
                    drive_data = 1'b1;
                end
            end
            DONE: begin
                if (rply_s) begin
                    state_next = IDLE;
                    ack_next   = 1'b1;
                end else begin
                    sync_next = 1'b0;
                end
            end
            GRANT: begin
                if (!sack_s) begin
                    state_next = HOLD;
                end else if (dmr_s) begin
                    state_next = IDLE;
                end else begin
                    dmgo_next = 1'b0;
                end
            end
            HOLD: begin
                if (sack_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (drive_data) begin
            sync_next = 1'b0;
            if (we_reg) begin
                ad_oe_next  = 1'b1;
                ad_out_next = wdata_reg;
                dout_next   = 1'b0;
                wtbt_next   = ~byte_reg;
            end else begin
                din_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            byte_reg   <= 1'b0;
            wdata_reg  <= '0;
            sync_reg   <= 1'b1;
            din_reg    <= 1'b1;
            dout_reg   <= 1'b1;
            wtbt_reg   <= 1'b1;
            dmgo_reg   <= 1'b1;
            ad_oe_reg  <= 1'b0;
            ad_out_reg <= '0;
            ack_reg    <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            we_reg     <= we_next;
            byte_reg   <= byte_next;
            wdata_reg  <= wdata_next;
            sync_reg   <= sync_next;
            din_reg    <= din_next;
            dout_reg   <= dout_next;
            wtbt_reg   <= wtbt_next;
            dmgo_reg   <= dmgo_next;
            ad_oe_reg  <= ad_oe_next;
            ad_out_reg <= ad_out_next;
            ack_reg    <= ack_next;
            err_reg    <= err_next;
            rdata_reg  <= rdata_next;
        end
    end

    assign ack    = ack_reg;
    assign err    = err_reg;
    assign rdata  = rdata_reg;
    assign busy   = (state_reg != IDLE);
    assign sync   = sync_reg;
    assign din    = din_reg;
    assign dout   = dout_reg;
    assign wtbt   = wtbt_reg;
    assign ad_out = ad_out_reg;
    assign ad_oe  = ad_oe_reg;
    assign dmgo   = dmgo_reg;

endmodule

// File: tb/tb_qbus_master_seq.sv
// Bench for qbus_master_seq: scripted bus cycles against a reply-on-strobe slave,
// with completion results checked through an expected-result queue.
module tb_qbus_master_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        byte_en = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] ad_in = '0;
    logic        rply = 1'b1;
    logic        dmr = 1'b1;
    logic        sack = 1'b1;
    logic        ack, err, busy, sync, din, dout, wtbt, ad_oe, dmgo;
    logic [15:0] rdata, ad_out;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] rdata_model = '0;
    logic [15:0] slave_data = '0;
    bit          slave_en = 1'b1;
    int          vec_cnt = 0;
    int          miss_cnt = 0;

    qbus_master_seq #(.TMO_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .byte_en(byte_en),
        .addr(addr), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata),
        .busy(busy), .sync(sync), .din(din), .dout(dout), .wtbt(wtbt),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .rply(rply),
        .dmr(dmr), .sack(sack), .dmgo(dmgo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec_cnt++;
        if (got !== want) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Slave answers any DIN/DOUT strobe with RPLY and releases it once the strobe ends.
    always @(negedge clk) begin
        if (slave_en && (!din || !dout)) begin
            rply  = 1'b0;
            ad_in = slave_data;
        end else begin
            rply = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst && ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("sb.unexpected_ack", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("sb.rdata", rdata, e.rdata);
                check_val("sb.err", err, e.err);
            end
        end
    end

    task automatic start_req(input bit w, input bit b, input logic [15:0] a, input logic [15:0] d,
                             input logic [15:0] sval, input bit exp_err, input bit push);
        exp_t e;
        we = w; byte_en = b; addr = a; wdata = d; slave_data = sval; req = 1'b1;
        if (push) begin
            if (exp_err)   rdata_model = '0;
            else if (!w)   rdata_model = sval;
            e.rdata = rdata_model;
            e.err   = exp_err;
            exp_q.push_back(e);
        end
    endtask

    task automatic finish_req(input string tag, input bit w, input bit b, input logic [15:0] a,
                              input logic [15:0] d, input bit dma_in_data, output int din_cnt);
        bit got_ack = 0, in_cyc = 0, sync_gap = 0, saw_dout = 0, addr_strobe = 0;
        logic [15:0] addr_seen = '0, data_ad = '0;
        logic addr_wtbt = 1'b1, addr_oe = 1'b0, data_wtbt = 1'b1, data_oe = 1'b0;
        logic din_oe = 1'b1, ack_sync = 1'b0;
        din_cnt = 0;
        for (int n = 0; n < 200 && !got_ack; n++) begin
            @(negedge clk);
            if (!in_cyc && !sync) begin
                in_cyc = 1; addr_seen = ad_out; addr_wtbt = wtbt; addr_oe = ad_oe;
                addr_strobe = !(din && dout);
            end else if (in_cyc && sync && !ack) begin
                sync_gap = 1;
            end
            if (!din) begin
                din_cnt++; din_oe = ad_oe;
                if (dma_in_data) dmr = 1'b0;
            end
            if (!dout) begin
                saw_dout = 1; data_ad = ad_out; data_wtbt = wtbt; data_oe = ad_oe;
            end
            if (ack) begin
                got_ack = 1; ack_sync = sync; req = 1'b0;
            end
        end
        check_val({tag, ".ack_seen"}, got_ack, 1);
        check_val({tag, ".addr"}, addr_seen, a);
        check_val({tag, ".addr_oe_wtbt"}, {addr_oe, addr_wtbt}, {1'b1, ~w});
        check_val({tag, ".addr_no_strobe"}, addr_strobe, 0);
        check_val({tag, ".sync_held"}, sync_gap, 0);
        check_val({tag, ".sync_ack"}, ack_sync, 1);
        if (w) begin
            check_val({tag, ".dout_seen"}, saw_dout, 1);
            check_val({tag, ".wdata"}, data_ad, d);
            check_val({tag, ".data_oe_wtbt"}, {data_oe, data_wtbt}, {1'b1, ~b});
            check_val({tag, ".no_din"}, din_cnt, 0);
        end else begin
            check_val({tag, ".din_seen"}, din_cnt > 0, 1);
            check_val({tag, ".din_oe"}, din_oe, 0);
            check_val({tag, ".no_dout"}, saw_dout, 0);
        end
    endtask

    task automatic post_idle(input string tag);
        @(negedge clk);
        check_val({tag, ".idle_busy_ack"}, {busy, ack}, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dc;
        bit  found;
        int  busy_cnt;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("reset.ctl", {sync, din, dout, wtbt, dmgo, ad_oe, ack, err, busy}, 9'b111110000);
        check_val("reset.ad_out", ad_out, 16'h0000);
        check_val("reset.rdata", rdata, 16'h0000);

        start_req(0, 0, 16'h1000, 16'h0000, 16'h0137, 0, 1);
        finish_req("rd1000", 0, 0, 16'h1000, 16'h0000, 0, dc);
        post_idle("rd1000");

        start_req(1, 0, 16'h2002, 16'hA5A5, 16'h0000, 0, 1);
        finish_req("wr_word", 1, 0, 16'h2002, 16'hA5A5, 0, dc);
        post_idle("wr_word");

        start_req(1, 1, 16'h2003, 16'h005A, 16'h0000, 0, 1);
        finish_req("wr_byte", 1, 1, 16'h2003, 16'h005A, 0, dc);
        post_idle("wr_byte");

        // DMA requested in the data phase: read finishes first, then grant.
        start_req(0, 0, 16'h3000, 16'h0000, 16'hBEEF, 0, 1);
        finish_req("dma_rd", 0, 0, 16'h3000, 16'h0000, 1, dc);
        @(negedge clk);
        check_val("dma.grant_dmgo_ack", {dmgo, ack}, 2'b00);
        start_req(0, 0, 16'h3002, 16'h0000, 16'h4242, 0, 1);
        sack = 1'b0;
        found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            if (dmgo) found = 1;
        end
        check_val("dma.hold_dmgo", found, 1);
        check_val("dma.hold_bus", {sync, din, dout, wtbt, ad_oe}, 5'b11110);
        dmr = 1'b1;
        repeat (4) @(negedge clk);
        check_val("dma.hold_keep", {sync, busy}, 2'b11);
        sack = 1'b1;
        finish_req("dma_pend", 0, 0, 16'h3002, 16'h0000, 0, dc);
        post_idle("dma_pend");

        // DMA request withdrawn without SACK.
        dmr = 1'b0;
        found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            if (!dmgo) found = 1;
        end
        check_val("dmaw.grant", found, 1);
        dmr = 1'b1;
        found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            if (dmgo) found = 1;
        end
        check_val("dmaw.release", found, 1);
        @(negedge clk);
        check_val("dmaw.idle_bus", {sync, din, dout, wtbt, ad_oe, busy, dmgo}, 7'b1111001);

        slave_en = 1'b0;
`ifdef QBUS_TIMEOUT_EN
        start_req(0, 0, 16'h5000, 16'h0000, 16'h0000, 1, 1);
        finish_req("tmo", 0, 0, 16'h5000, 16'h0000, 0, dc);
        check_val("tmo.data_clocks", dc, 8);
        post_idle("tmo");
`else
        start_req(0, 0, 16'h5000, 16'h0000, 16'h0000, 0, 0);
        busy_cnt = 0;
        for (int n = 0; n < 110; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check_val("notmo.busy_held", busy_cnt >= 100, 1);
        check_val("notmo.din_held", din, 0);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rdata_model = '0;
        check_val("notmo.reset_busy", busy, 0);
`endif

        // Reset during the data phase of a write.
        start_req(1, 0, 16'h6006, 16'h1234, 16'h0000, 0, 0);
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (!dout) found = 1;
        end
        check_val("rst_data.dout_seen", found, 1);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rdata_model = '0;
        check_val("rst_data.bus", {sync, dout, wtbt, din, ad_oe, busy, ack}, 7'b1111000);
        repeat (4) @(negedge clk);
        check_val("rst_data.quiet", {busy, ack, sync}, 3'b001);
        slave_en = 1'b1;

        start_req(0, 0, 16'hFFFE, 16'h0000, 16'hC0DE, 0, 1);
        finish_req("rd_last", 0, 0, 16'hFFFE, 16'h0000, 0, dc);
        post_idle("rd_last");

        check_val("sb.drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
